// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with operand forwarding, a single-cycle ALU and
// an iterative radix-2 multiply/divide unit (RV32M op set). Owns the EX/MEM
// pipeline register. Multi-cycle MD ops hold upstream through stall_o.
// Optional feature: define EX_MD_DIV_EN to build the divider; without it,
// DIV/DIVU/REM/REMU complete in one cycle with result 0 and no stall.
// ALU encoding (alu_op_i): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL,
// 7 SRA, 8 OR, 9 AND, 10 pass opB, others 0.
module ex_stage_md #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MEM_OP_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  id_valid_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic [DATA_WIDTH-1:0] imm_i,
   input  logic [REG_ADDR_W-1:0] rd_add_i,
   input  logic                  regwrite_i,
   input  logic                  rd_mem_i,
   input  logic                  wr_mem_i,
   input  logic [MEM_OP_W-1:0]   mem_op_i,
   input  logic [1:0]            sel_to_reg_i,
   input  logic                  branch_i,
   input  logic                  jump_i,
   input  logic [3:0]            alu_op_i,
   input  logic                  md_req_i,
   input  logic [2:0]            md_op_i,
   input  logic                  sel_alu1_i,
   input  logic                  sel_alu2_i,
   input  logic [1:0]            fwd_a_i,
   input  logic [1:0]            fwd_b_i,
   input  logic [DATA_WIDTH-1:0] mem_fwd_i,
   input  logic [DATA_WIDTH-1:0] wb_fwd_i,
   output logic                  stall_o,
   output logic                  ex_valid_o,
   output logic [DATA_WIDTH-1:0] ex_result_o,
   output logic                  ex_zero_o,
   output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
   output logic [DATA_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [DATA_WIDTH-1:0] ex_pc_dest_o,
   output logic [REG_ADDR_W-1:0] ex_rd_add_o,
   output logic                  ex_regwrite_o,
   output logic                  ex_rd_mem_o,
   output logic                  ex_wr_mem_o,
   output logic [MEM_OP_W-1:0]   ex_mem_op_o,
   output logic [1:0]            ex_sel_to_reg_o,
   output logic                  ex_branch_o,
   output logic                  ex_jump_o
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

   typedef struct packed {
      logic                  valid;
      logic [W-1:0]          result;
      logic                  zero;
      logic [W-1:0]          rs2;
      logic [W-1:0]          pc;
      logic [W-1:0]          imm;
      logic [REG_ADDR_W-1:0] rd_add;
      logic                  regwrite;
      logic                  rd_mem;
      logic                  wr_mem;
      logic [MEM_OP_W-1:0]   mem_op;
      logic [1:0]            sel_to_reg;
      logic                  branch;
      logic                  jump;
   } ex_mem_t;

   logic [W-1:0]     rs1_fwd, rs2_fwd, op_a, op_b, alu_res;
   logic [CNT_W-1:0] shamt;
   logic             a_neg, b_neg, md_start, md_nodiv_op;
   logic [W-1:0]     a_mag, b_mag, md_result;
   logic [2*W-1:0]   mul_step, mul_full;
   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     opnd_q, opnd_d;
   logic [2:0]       op_q, op_d;
   logic             neg_q, neg_d;
`ifdef EX_MD_DIV_EN
   logic [2*W-1:0]   div_step;
   logic [W:0]       div_shift, div_diff;
   logic             rneg_q, rneg_d;
`endif
   ex_mem_t          ex_q, ex_d;

   // Operand forwarding, then pc/imm selection for the ALU inputs.
   always_comb begin
      case (fwd_a_i)
         2'b01:   rs1_fwd = mem_fwd_i;
         2'b10:   rs1_fwd = wb_fwd_i;
         default: rs1_fwd = rs1_data_i;
      endcase
      case (fwd_b_i)
         2'b01:   rs2_fwd = mem_fwd_i;
         2'b10:   rs2_fwd = wb_fwd_i;
         default: rs2_fwd = rs2_data_i;
      endcase
      op_a  = sel_alu1_i ? pc_i : rs1_fwd;
      op_b  = sel_alu2_i ? imm_i : rs2_fwd;
      shamt = op_b[CNT_W-1:0];
   end

   // Single-cycle ALU.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      alu_res = '0;
      case (alu_op_i)
         4'd0:  alu_res = op_a + op_b;
         4'd1:  alu_res = op_a - op_b;
         4'd2:  alu_res = op_a << shamt;
         4'd3:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'd4:  alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
         4'd5:  alu_res = op_a ^ op_b;
         4'd6:  alu_res = op_a >> shamt;
         4'd7:  alu_res = $signed(op_a) >>> shamt;
         4'd8:  alu_res = op_a | op_b;
         4'd9:  alu_res = op_a & op_b;
         4'd10: alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   // Operand sign handling, iteration steps and final sign correction of the MD unit.
   always_comb begin
      // MULH and MULHSU treat rs1 as signed, only MULH treats rs2 as signed;
      // DIV and REM (md_op_i[0]=0) are signed on both operands.
      if (md_op_i[2]) begin
         a_neg = !md_op_i[0] && rs1_fwd[W-1];
         b_neg = !md_op_i[0] && rs2_fwd[W-1];
      end else begin
         a_neg = (md_op_i[1:0] == 2'b01 || md_op_i[1:0] == 2'b10) && rs1_fwd[W-1];
         b_neg = (md_op_i[1:0] == 2'b01) && rs2_fwd[W-1];
      end
      a_mag = a_neg ? -rs1_fwd : rs1_fwd;
      b_mag = b_neg ? -rs2_fwd : rs2_fwd;
`ifdef EX_MD_DIV_EN
      md_nodiv_op = 1'b0;
`else
      md_nodiv_op = md_req_i && md_op_i[2];
`endif
      md_start = id_valid_i && md_req_i && !md_nodiv_op && !flush && (state_q == MD_IDLE);

      // Shift-add: acc = {partial, multiplier}, add multiplicand when lsb set, shift right.
      mul_step = {({1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0)), acc_q[W-1:1]};
      mul_full = neg_q ? -acc_q : acc_q;
      md_result = (op_q == 3'b000) ? mul_full[W-1:0] : mul_full[2*W-1:W];
`ifdef EX_MD_DIV_EN
      // Restoring division: acc = {remainder, quotient/dividend}. A zero divisor
      // naturally yields an all-ones quotient and the dividend as remainder, and
      // the most-negative / -1 case yields the dividend with remainder 0.
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_step  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                              : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      if (op_q[2]) begin
         md_result = op_q[1] ? (rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W])
                             : (neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
      end
`endif
      stall_o = !rst && !flush &&
                (md_start || (state_q == MD_BUSY) ||
                 (state_q == MD_IDLE && id_valid_i && md_req_i && !md_nodiv_op));
   end

   // MD control FSM: IDLE latches operands, BUSY iterates W times, DONE hands the result over.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      op_d    = op_q;
      neg_d   = neg_q;
`ifdef EX_MD_DIV_EN
      rneg_d  = rneg_q;
`endif
      case (state_q)
         MD_IDLE: begin
            if (md_start) begin
               state_d = MD_BUSY;
               count_d = '0;
               op_d    = md_op_i;
               neg_d   = a_neg ^ b_neg;
               acc_d   = {{W{1'b0}}, b_mag};
               opnd_d  = a_mag;
`ifdef EX_MD_DIV_EN
               rneg_d  = a_neg;
               if (md_op_i[2]) begin
                  neg_d  = (a_neg ^ b_neg) && (rs2_fwd != '0);
                  acc_d  = {{W{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end
`endif
            end
         end
         MD_BUSY: begin
            acc_d = mul_step;
`ifdef EX_MD_DIV_EN
            if (op_q[2]) acc_d = div_step;
`endif
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(W - 1)) begin
               state_d = MD_DONE;
               count_d = '0;
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
      if (flush) begin
         state_d = MD_IDLE;
         count_d = '0;
      end
   end

   // MD state register; operand/accumulator flops carry no reset since they are loaded before use.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
`ifdef EX_MD_DIV_EN
      rneg_q <= rneg_d;
`endif
   end

   // Next EX/MEM contents: ALU or MD result, with a bubble on stall or empty ID/EX.
   always_comb begin
      ex_d            = '0;
      ex_d.valid      = id_valid_i;
      ex_d.result     = (state_q == MD_DONE) ? md_result : (md_nodiv_op ? '0 : alu_res);
      ex_d.zero       = (alu_res == '0);
      ex_d.rs2        = rs2_fwd;
      ex_d.pc         = pc_i;
      ex_d.imm        = imm_i;
      ex_d.rd_add     = rd_add_i;
      ex_d.regwrite   = regwrite_i;
      ex_d.rd_mem     = rd_mem_i;
      ex_d.wr_mem     = wr_mem_i;
      ex_d.mem_op     = mem_op_i;
      ex_d.sel_to_reg = sel_to_reg_i;
      ex_d.branch     = branch_i;
      ex_d.jump       = jump_i;
      if (stall_o || !id_valid_i) begin
         ex_d.valid    = 1'b0;
         ex_d.regwrite = 1'b0;
         ex_d.rd_mem   = 1'b0;
         ex_d.wr_mem   = 1'b0;
         ex_d.branch   = 1'b0;
         ex_d.jump     = 1'b0;
      end
   end

   // EX/MEM pipeline register, cleared by reset or flush.
   always_ff @(posedge clk) begin
      if (rst || flush) ex_q <= '0;
      else              ex_q <= ex_d;
   end

   assign ex_valid_o      = ex_q.valid;
   assign ex_result_o     = ex_q.result;
   assign ex_zero_o       = ex_q.zero;
   assign ex_rs2_data_o   = ex_q.rs2;
   assign ex_pc_o         = ex_q.pc;
   assign ex_imm_o        = ex_q.imm;
   assign ex_pc_dest_o    = ex_q.pc + ex_q.imm;
   assign ex_rd_add_o     = ex_q.rd_add;
   assign ex_regwrite_o   = ex_q.regwrite;
   assign ex_rd_mem_o     = ex_q.rd_mem;
   assign ex_wr_mem_o     = ex_q.wr_mem;
   assign ex_mem_op_o     = ex_q.mem_op;
   assign ex_sel_to_reg_o = ex_q.sel_to_reg;
   assign ex_branch_o     = ex_q.branch;
   assign ex_jump_o       = ex_q.jump;
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed bench for ex_stage_md (32-bit defaults). ALU cases
// come from a vector table; MD ops, reset and flush use hand-written sequences.
module tb_ex_stage_md;
   logic        clk = 1'b0;
   logic        rst, flush, id_valid, regwrite, rd_mem, wr_mem, branch, jump;
   logic        md_req, sel1, sel2;
   logic [31:0] pc, rs1, rs2, imm, mem_fwd, wb_fwd;
   logic [4:0]  rd_add;
   logic [3:0]  mem_op, alu_op;
   logic [1:0]  sel_to_reg, fwd_a, fwd_b;
   logic [2:0]  md_op;
   logic        stall_o, ex_valid_o, ex_zero_o, ex_regwrite_o, ex_rd_mem_o, ex_wr_mem_o;
   logic        ex_branch_o, ex_jump_o;
   logic [31:0] ex_result_o, ex_rs2_data_o, ex_pc_o, ex_imm_o, ex_pc_dest_o;
   logic [4:0]  ex_rd_add_o;
   logic [3:0]  ex_mem_op_o;
   logic [1:0]  ex_sel_to_reg_o;

   int tests = 0;
   int fails = 0;

   ex_stage_md dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid_i(id_valid), .pc_i(pc),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm), .rd_add_i(rd_add),
      .regwrite_i(regwrite), .rd_mem_i(rd_mem), .wr_mem_i(wr_mem), .mem_op_i(mem_op),
      .sel_to_reg_i(sel_to_reg), .branch_i(branch), .jump_i(jump), .alu_op_i(alu_op),
      .md_req_i(md_req), .md_op_i(md_op), .sel_alu1_i(sel1), .sel_alu2_i(sel2),
      .fwd_a_i(fwd_a), .fwd_b_i(fwd_b), .mem_fwd_i(mem_fwd), .wb_fwd_i(wb_fwd),
      .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_result_o(ex_result_o),
      .ex_zero_o(ex_zero_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_pc_o(ex_pc_o),
      .ex_imm_o(ex_imm_o), .ex_pc_dest_o(ex_pc_dest_o), .ex_rd_add_o(ex_rd_add_o),
      .ex_regwrite_o(ex_regwrite_o), .ex_rd_mem_o(ex_rd_mem_o), .ex_wr_mem_o(ex_wr_mem_o),
      .ex_mem_op_o(ex_mem_op_o), .ex_sel_to_reg_o(ex_sel_to_reg_o),
      .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  alu_op;
      logic [31:0] rs1, rs2, imm, pc, mem_fwd, wb_fwd;
      logic [1:0]  fwd_a, fwd_b;
      logic        sel1, sel2;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic [31:0] exp_rs2, exp_dest;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      id_valid = 1'b0; md_req = 1'b0; md_op = 3'd0; alu_op = 4'd0;
      pc = '0; rs1 = '0; rs2 = '0; imm = '0; mem_fwd = '0; wb_fwd = '0;
      rd_add = '0; regwrite = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0; mem_op = '0;
      sel_to_reg = '0; branch = 1'b0; jump = 1'b0; sel1 = 1'b0; sel2 = 1'b0;
      fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one MD op from a post-edge slot, counts stall cycles, checks the captured result.
   task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
      int cyc;
      drive_idle();
      id_valid = 1'b1; md_req = 1'b1; md_op = op; rs1 = a; rs2 = b;
      rd_add = 5'd7; regwrite = 1'b1;
      #1;
      cyc = 0;
      while (stall_o && cyc < 200) begin
         tick();
         cyc++;
      end
      check({name, "_stall_cycles"}, cyc, exp_stall);
      tick();
      check({name, "_result"}, ex_result_o, exp);
      check({name, "_valid_rd"}, {ex_valid_o, ex_regwrite_o, ex_rd_add_o}, {1'b1, 1'b1, 5'd7});
      drive_idle();
   endtask

   initial begin
      vecs[0] = '{"add",       4'd0, 32'd5, 32'd7, 32'd0, 32'h0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd12, 1'b0, 32'd7, 32'h0};
      vecs[1] = '{"sub_zero",  4'd1, 32'd3, 32'd3, 32'd0, 32'h0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 32'd3, 32'h0};
      vecs[2] = '{"fwd_mem",   4'd0, 32'd1, 32'd9, 32'd4, 32'h100, 32'h10, 32'd0, 2'b01, 2'b00, 1'b0, 1'b1, 32'h14, 1'b0, 32'd9, 32'h104};
      vecs[3] = '{"fwd_wb_b",  4'd0, 32'd5, 32'd1, 32'd0, 32'h0, 32'd0, 32'h20, 2'b00, 2'b10, 1'b0, 1'b0, 32'h25, 1'b0, 32'h20, 32'h0};
      vecs[4] = '{"slt",       4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd1, 1'b0, 32'd1, 32'h0};
      vecs[5] = '{"sltu",      4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1, 32'd1, 32'h0};
      vecs[6] = '{"sra",       4'd7, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hF800_0000, 1'b0, 32'd4, 32'h0};
      vecs[7] = '{"and",       4'd9, 32'hF0F0, 32'hFF00, 32'd0, 32'h0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hF000, 1'b0, 32'hFF00, 32'h0};
      vecs[8] = '{"pc_imm",    4'd0, 32'd77, 32'd0, 32'd8, 32'h200, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b1, 32'h208, 1'b0, 32'd0, 32'h208};
      vecs[9] = '{"fwd_11_rf", 4'd0, 32'd9, 32'd1, 32'd0, 32'h0, 32'd100, 32'd200, 2'b11, 2'b11, 1'b0, 1'b0, 32'd10, 1'b0, 32'd1, 32'h0};

      // Reset held two cycles with an MD request pending: stall must stay low.
      drive_idle();
      flush = 1'b0;
      rst = 1'b1;
      id_valid = 1'b1; md_req = 1'b1; rs1 = 32'd3; rs2 = 32'd4;
      tick();
      check("reset_stall", stall_o, 1'b0);
      tick();
      check("reset_stall2", stall_o, 1'b0);
      check("reset_data", {ex_result_o, ex_rs2_data_o, ex_pc_o, ex_imm_o, ex_pc_dest_o}, '0);
      check("reset_ctrl", {ex_valid_o, ex_zero_o, ex_rd_add_o, ex_regwrite_o, ex_rd_mem_o,
                           ex_wr_mem_o, ex_mem_op_o, ex_sel_to_reg_o, ex_branch_o, ex_jump_o}, '0);
      rst = 1'b0;
      drive_idle();

      // Table-driven single-cycle ALU vectors.
      for (int i = 0; i < 10; i++) begin
         drive_idle();
         id_valid = 1'b1; regwrite = 1'b1; rd_add = 5'(i + 1);
         alu_op = vecs[i].alu_op; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; imm = vecs[i].imm;
         pc = vecs[i].pc; mem_fwd = vecs[i].mem_fwd; wb_fwd = vecs[i].wb_fwd;
         fwd_a = vecs[i].fwd_a; fwd_b = vecs[i].fwd_b; sel1 = vecs[i].sel1; sel2 = vecs[i].sel2;
         #1;
         check({vecs[i].name, "_nostall"}, stall_o, 1'b0);
         tick();
         check({vecs[i].name, "_result"}, ex_result_o, vecs[i].exp_res);
         check({vecs[i].name, "_zero"}, ex_zero_o, vecs[i].exp_zero);
         check({vecs[i].name, "_rs2"}, ex_rs2_data_o, vecs[i].exp_rs2);
         check({vecs[i].name, "_pc_dest"}, ex_pc_dest_o, vecs[i].exp_dest);
         check({vecs[i].name, "_valid_rd"}, {ex_valid_o, ex_regwrite_o, ex_rd_add_o},
               {1'b1, 1'b1, 5'(i + 1)});
      end

      // Empty ID/EX: bubble propagates even with md_req high.
      drive_idle();
      md_req = 1'b1; regwrite = 1'b1; md_op = 3'b000;
      #1;
      check("bubble_nostall", stall_o, 1'b0);
      tick();
      check("bubble_ctrl", {ex_valid_o, ex_regwrite_o}, 2'b00);
      drive_idle();

      // Multiplies: W+1 = 33 stall cycles each.
      run_md("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_md("mul",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      run_md("mulh",  3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
      run_md("mulhsu",3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

`ifdef EX_MD_DIV_EN
      run_md("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run_md("divu_by0", 3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 33);
      run_md("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_md("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_md("remu_by0", 3'b111, 32'd7,         32'd0,         32'd7,         33);
`else
      run_md("div_off",  3'b100, 32'd100, 32'd7, 32'd0, 0);
      run_md("remu_off", 3'b111, 32'd100, 32'd7, 32'd0, 0);
`endif

      // Flush at BUSY count 10: stall drops the same cycle and nothing is written.
      drive_idle();
      id_valid = 1'b1; md_req = 1'b1; md_op = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
      rd_add = 5'd3; regwrite = 1'b1;
      #1;
      check("flush_pre_stall", stall_o, 1'b1);
      for (int i = 0; i < 11; i++) tick();
      check("flush_busy_stall", stall_o, 1'b1);
      flush = 1'b1;
      #1;
      check("flush_stall_drop", stall_o, 1'b0);
      tick();
      flush = 1'b0;
      drive_idle();
      check("flush_ex_valid", {ex_valid_o, ex_regwrite_o}, 2'b00);
      #1;
      check("flush_idle_stall", stall_o, 1'b0);
      tick();
      run_md("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
